// File: rtl/shift_seq9900.sv
// Multi-cycle sequencer for TMS9900 SLA/SRA/SRC/SRL.
// Drives a single-bit-shift ALU one pass per clock and accumulates status.
module shift_seq9900 #(
    parameter bit R0_COUNT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  shift_op,
    input  logic [3:0]  count_field,
    input  logic [3:0]  r0_low,
    input  logic [15:0] operand,
    output logic [3:0]  alu_ope,
    output logic [15:0] alu_arg2,
    input  logic [15:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_ovf,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        st_lgt,
    output logic        st_agt,
    output logic        st_eq,
    output logic        st_c,
    output logic        st_o
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  op;
    logic [15:0] work;
    logic [4:0]  cnt;
    logic        c_acc;
    logic        o_acc;
    logic [4:0]  n_cnt;
    logic        o_nxt;

    assign alu_ope  = op;
    assign alu_arg2 = work;

    // A zero count field falls back to R0, where zero again means 16.
    always_comb begin
        n_cnt = 5'd16;
        if (count_field != 4'h0)
            n_cnt = {1'b0, count_field};
        else if (R0_COUNT && r0_low != 4'h0)
            n_cnt = {1'b0, r0_low};
    end

    // Overflow only accumulates for arithmetic left shifts.
    assign o_nxt = o_acc | (alu_ovf & (op == 4'hc));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op     <= 4'hf;
            work   <= 16'h0000;
            cnt    <= 5'd0;
            c_acc  <= 1'b0;
            o_acc  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 16'h0000;
            st_lgt <= 1'b0;
            st_agt <= 1'b0;
            st_eq  <= 1'b0;
            st_c   <= 1'b0;
            st_o   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op    <= {2'b11, shift_op[1:0]};
                        work  <= operand;
                        cnt   <= n_cnt;
                        c_acc <= 1'b0;
                        o_acc <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= alu_result;
                    c_acc <= alu_carry;
                    o_acc <= o_nxt;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= alu_result;
                        st_eq  <= (alu_result == 16'h0000);
                        st_lgt <= (alu_result != 16'h0000);
                        st_agt <= !alu_result[15]
                                  && (alu_result != 16'h0000);
                        st_c   <= alu_carry;
                        st_o   <= o_nxt;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq9900.sv
// Directed bench for shift_seq9900 with a behavioural single-bit ALU.
// Expected values are hand-computed per scenario.
module tb_shift_seq9900;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  shift_op;
    logic [3:0]  count_field;
    logic [3:0]  r0_low;
    logic [15:0] operand;
    logic [3:0]  alu_ope;
    logic [15:0] alu_arg2;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_ovf;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        st_lgt;
    logic        st_agt;
    logic        st_eq;
    logic        st_c;
    logic        st_o;

    int total;
    int bad;

    shift_seq9900 dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .shift_op(shift_op),
        .count_field(count_field),
        .r0_low(r0_low),
        .operand(operand),
        .alu_ope(alu_ope),
        .alu_arg2(alu_arg2),
        .alu_result(alu_result),
        .alu_carry(alu_carry),
        .alu_ovf(alu_ovf),
        .busy(busy),
        .done(done),
        .result(result),
        .st_lgt(st_lgt),
        .st_agt(st_agt),
        .st_eq(st_eq),
        .st_c(st_c),
        .st_o(st_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-bit shift ALU
    always_comb begin
        alu_result = 16'h0000;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_ope)
            4'hc: begin
                alu_result = {alu_arg2[14:0], 1'b0};
                alu_carry  = alu_arg2[15];
                alu_ovf    = alu_arg2[15] ^ alu_arg2[14];
            end
            4'hd: begin
                alu_result = {alu_arg2[15], alu_arg2[15:1]};
                alu_carry  = alu_arg2[0];
            end
            4'he: begin
                alu_result = {alu_arg2[0], alu_arg2[15:1]};
                alu_carry  = alu_arg2[0];
            end
            default: begin
                alu_result = {1'b0, alu_arg2[15:1]};
                alu_carry  = alu_arg2[0];
            end
        endcase
    end

    // Pulse start, then count edges (accepting edge = 1) until done.
    task automatic run_op(input logic [3:0] op, input logic [3:0] cf,
                          input logic [3:0] r0, input logic [15:0] opnd,
                          output int lat);
        @(posedge clk); #1;
        shift_op = op; count_field = cf; r0_low = r0; operand = opnd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=00", {busy, done});
        end
        total++;
        if (result !== 16'h0000) begin
            bad++;
            $display("FAIL reset_result got=%h want=0000", result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_st got=%b want=00000",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
        total++;
        if (alu_ope !== 4'hf || alu_arg2 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_alu got=%h/%h want=f/0000",
                     alu_ope, alu_arg2);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_sra;
        int lat;
        run_op(4'hd, 4'd1, 4'd0, 16'h8001, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL sra_lat got=%0d want=2", lat);
        end
        total++;
        if (result !== 16'hc000) begin
            bad++;
            $display("FAIL sra_result got=%h want=c000", result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b10010) begin
            bad++;
            $display("FAIL sra_st got=%b want=10010",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL sra_busy_done got=%b want=1", busy);
        end
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00 || result !== 16'hc000) begin
            bad++;
            $display("FAIL sra_hold got=%b %h want=00 c000",
                     {busy, done}, result);
        end
    endtask

    task automatic test_sla;
        int lat;
        run_op(4'hc, 4'd2, 4'd0, 16'h4000, lat);
        total++;
        if (lat !== 3 || result !== 16'h0000) begin
            bad++;
            $display("FAIL sla got=%0d %h want=3 0000", lat, result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b00111) begin
            bad++;
            $display("FAIL sla_st got=%b want=00111",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
    endtask

    task automatic test_src;
        int lat;
        run_op(4'he, 4'd4, 4'd0, 16'h1234, lat);
        total++;
        if (lat !== 5 || result !== 16'h4123) begin
            bad++;
            $display("FAIL src got=%0d %h want=5 4123", lat, result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b11000) begin
            bad++;
            $display("FAIL src_st got=%b want=11000",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
    endtask

    task automatic test_srl_r0;
        int lat;
        run_op(4'hf, 4'd0, 4'd0, 16'hffff, lat);
        total++;
        if (lat !== 17 || result !== 16'h0000) begin
            bad++;
            $display("FAIL srl16 got=%0d %h want=17 0000", lat, result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b00110) begin
            bad++;
            $display("FAIL srl16_st got=%b want=00110",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
        run_op(4'hf, 4'd0, 4'd3, 16'h0008, lat);
        total++;
        if (lat !== 4 || result !== 16'h0001) begin
            bad++;
            $display("FAIL srl_r0 got=%0d %h want=4 0001", lat, result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b11000) begin
            bad++;
            $display("FAIL srl_r0_st got=%b want=11000",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(posedge clk); #1;
        shift_op = 4'hf; count_field = 4'd8; operand = 16'hf000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin
            @(posedge clk); #1;
            lat++;
        end
        shift_op = 4'hc; count_field = 4'd1; operand = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 9 || result !== 16'h00f0) begin
            bad++;
            $display("FAIL ign_busy got=%0d %h want=9 00f0", lat, result);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_done_start busy got=%b want=0", busy);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || result !== 16'h00f0) begin
            bad++;
            $display("FAIL ign_done_hold got=%b %h want=0 00f0",
                     busy, result);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        @(posedge clk); #1;
        shift_op = 4'hd; count_field = 4'd10; operand = 16'h8000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || result !== 16'h0000 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got=%b%b %h want=00 0000",
                     busy, done, result);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_nodone got=%b want=0", seen);
        end
        run_op(4'hc, 4'd3, 4'd0, 16'h0001, lat);
        total++;
        if (lat !== 4 || result !== 16'h0008) begin
            bad++;
            $display("FAIL rst_after got=%0d %h want=4 0008", lat, result);
        end
        total++;
        if ({st_lgt, st_agt, st_eq, st_c, st_o} !== 5'b11000) begin
            bad++;
            $display("FAIL rst_after_st got=%b want=11000",
                     {st_lgt, st_agt, st_eq, st_c, st_o});
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        start = 1'b0;
        shift_op = 4'hf;
        count_field = 4'd0;
        r0_low = 4'd0;
        operand = 16'h0000;
        test_reset;
        test_sra;
        test_sla;
        test_src;
        test_srl_r0;
        test_ignore_start;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
